// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RISC-V datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Outputs are decoded combinationally from the state register; write strobes are forced low while RST is low.
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] Instr6_0,
    input  logic [2:0] Instr14_12,
    input  logic       Instr30,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc1_0,
    output logic [2:0] ALUControl2_0,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc1_0,
    output logic       RegWrite,
    output logic       IllegalInstr,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU operation selected by funct3/funct7[5]; subtraction only for R-type encodings
    function automatic logic [2:0] alu_funct(input logic [2:0] f3, input logic op5, input logic f7b5);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       ready_s;
    logic       pcwrite_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       illegal_s;
    logic       adrsrc_s;
    logic [1:0] resultsrc_s;
    logic [2:0] aluctl_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] immsrc_s;

    assign ready_s = MEM_HANDSHAKE ? MemReady : 1'b1;

    // State register; asynchronous reset returns to FETCH and aborts the instruction in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (ready_s) state_next_s = S_DECODE;
                else         state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (Instr6_0)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_R:         state_next_s = S_EXECUTER;
                    OP_I:         state_next_s = S_EXECUTEI;
                    OP_BEQ:       state_next_s = S_BEQ;
                    OP_JAL:       state_next_s = S_JAL;
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Instr6_0 == OP_LW) state_next_s = S_MEMREAD;
                else                   state_next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (ready_s) state_next_s = S_MEMWB;
                else         state_next_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (ready_s) state_next_s = S_FETCH;
                else         state_next_s = S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI: state_next_s = S_ALUWB;
            S_JAL:                  state_next_s = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_next_s = S_FETCH;
            default:                state_next_s = S_FETCH;
        endcase
    end

    // Datapath selects and raw strobes for the current state
    always_comb begin
        pcwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        illegal_s   = 1'b0;
        adrsrc_s    = 1'b0;
        resultsrc_s = 2'b00;
        aluctl_s    = ALU_ADD;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        case (state_r)
            S_FETCH: begin
                alusrcb_s   = 2'b10;
                resultsrc_s = 2'b10;
                irwrite_s   = ready_s;
                pcwrite_s   = ready_s;
            end
            S_DECODE: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                case (Instr6_0)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_s = 1'b0;
                    default:                                  illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
            end
            S_MEMREAD: begin
                adrsrc_s = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc_s   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTER: begin
                alusrca_s = 2'b10;
                aluctl_s  = alu_funct(Instr14_12, Instr6_0[5], Instr30);
            end
            S_EXECUTEI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluctl_s  = alu_funct(Instr14_12, Instr6_0[5], Instr30);
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
            end
            S_JAL: begin
                alusrca_s = 2'b01;
                alusrcb_s = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca_s = 2'b10;
                aluctl_s  = ALU_SUB;
                pcwrite_s = Zero;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (Instr6_0)
            OP_SW:   immsrc_s = 2'b01;
            OP_BEQ:  immsrc_s = 2'b10;
            OP_JAL:  immsrc_s = 2'b11;
            default: immsrc_s = 2'b00;
        endcase
    end

    assign PCWrite       = pcwrite_s  & RST;
    assign MemWrite      = memwrite_s & RST;
    assign IRWrite       = irwrite_s  & RST;
    assign RegWrite      = regwrite_s & RST;
    assign IllegalInstr  = illegal_s  & RST;
    assign AdrSrc        = adrsrc_s;
    assign ResultSrc1_0  = resultsrc_s;
    assign ALUControl2_0 = aluctl_s;
    assign ALUSrcA       = alusrca_s;
    assign ALUSrcB       = alusrcb_s;
    assign ImmSrc1_0     = immsrc_s;
    assign State         = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: walks directed and random instructions through the controller and compares
// every cycle against a phase-list model of the instruction sequencing.
module tb_multicycle_controller;

    logic       CLK;
    logic       RST;
    logic [6:0] Instr6_0;
    logic [2:0] Instr14_12;
    logic       Instr30;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc1_0, ALUSrcA, ALUSrcB, ImmSrc1_0;
    logic [2:0] ALUControl2_0;
    logic [3:0] State;

    int n_checks = 0;
    int n_fails  = 0;

    multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
        .CLK(CLK), .RST(RST), .Instr6_0(Instr6_0), .Instr14_12(Instr14_12), .Instr30(Instr30),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc1_0(ResultSrc1_0), .ALUControl2_0(ALUControl2_0),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc1_0(ImmSrc1_0), .RegWrite(RegWrite),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Phases of an instruction; the numeric value is the debug State code the controller reports
    typedef enum int {
        P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
        P_XR = 6, P_XI = 7, P_AWB = 8, P_BEQ = 9, P_JAL = 10
    } phase_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    phase_t plan[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit supported(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == BQ) || (op == JL);
    endfunction

    // Expected ALU operation for the execute phases, from the funct rules
    function automatic int exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic i30);
        if (f3 == 3'd0) return (op == RT && i30) ? 1 : 0;
        if (f3 == 3'd2) return 5;
        if (f3 == 3'd6) return 3;
        if (f3 == 3'd7) return 2;
        return 0;
    endfunction

    function automatic void build_plan(input logic [6:0] op);
        plan = {P_F, P_D};
        if (op == LW)      plan = {plan, P_MA, P_MR, P_MWB};
        else if (op == SW) plan = {plan, P_MA, P_MW};
        else if (op == RT) plan = {plan, P_XR, P_AWB};
        else if (op == IT) plan = {plan, P_XI, P_AWB};
        else if (op == BQ) plan = {plan, P_BEQ};
        else if (op == JL) plan = {plan, P_JAL, P_AWB};
    endfunction

    // One clock of one phase: drive, check mid-cycle, advance past the next rising edge
    task automatic step(input phase_t p, input bit rdy, input bit z);
        int a, b, alu, res, adr, imm;
        MemReady = rdy;
        Zero     = z;
        @(negedge CLK);
        a = -1; b = -1; alu = -1; res = -1; adr = -1;
        case (p)
            P_F:   begin a = 0; b = 2; alu = 0; res = 2; adr = 0; end
            P_D:   begin a = 1; b = 1; alu = 0; end
            P_MA:  begin a = 2; b = 1; alu = 0; end
            P_MR:  begin res = 0; adr = 1; end
            P_MWB: begin res = 1; end
            P_MW:  begin res = 0; adr = 1; end
            P_XR:  begin a = 2; b = 0; alu = exp_alu(Instr6_0, Instr14_12, Instr30); end
            P_XI:  begin a = 2; b = 1; alu = exp_alu(Instr6_0, Instr14_12, Instr30); end
            P_AWB: begin res = 0; end
            P_JAL: begin a = 1; b = 2; alu = 0; res = 0; end
            P_BEQ: begin a = 2; b = 0; alu = 1; res = 0; end
            default: begin a = -1; end
        endcase
        imm = (Instr6_0 == SW) ? 1 : (Instr6_0 == BQ) ? 2 : (Instr6_0 == JL) ? 3 : 0;
        chk($sformatf("state@%s", p.name()), int'(State), int'(p));
        chk("pcwrite",  int'(PCWrite),  int'((p == P_F && rdy) || p == P_JAL || (p == P_BEQ && z)));
        chk("irwrite",  int'(IRWrite),  int'(p == P_F && rdy));
        chk("memwrite", int'(MemWrite), int'(p == P_MW));
        chk("regwrite", int'(RegWrite), int'(p == P_MWB || p == P_AWB));
        chk("illegal",  int'(IllegalInstr), int'(p == P_D && !supported(Instr6_0)));
        chk("immsrc",   int'(ImmSrc1_0), imm);
        if (a >= 0)   chk("alusrca",   int'(ALUSrcA), a);
        if (b >= 0)   chk("alusrcb",   int'(ALUSrcB), b);
        if (alu >= 0) chk("alucontrol", int'(ALUControl2_0), alu);
        if (res >= 0) chk("resultsrc", int'(ResultSrc1_0), res);
        if (adr >= 0) chk("adrsrc",    int'(AdrSrc), adr);
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction; stalls<0 picks a random number of not-ready cycles per memory phase
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic i30,
                             input bit z, input int stalls);
        Instr6_0   = op;
        Instr14_12 = f3;
        Instr30    = i30;
        build_plan(op);
        foreach (plan[k]) begin
            phase_t p = plan[k];
            if (p == P_F || p == P_MR || p == P_MW) begin
                int n = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
                repeat (n) step(p, 1'b0, 1'($urandom_range(0, 1)));
                step(p, 1'b1, 1'($urandom_range(0, 1)));
            end else begin
                step(p, 1'($urandom_range(0, 1)), (p == P_BEQ) ? z : 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        logic [6:0] ops[6];
        ops = '{LW, SW, RT, IT, BQ, JL};
        RST = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        Instr6_0 = SW; Instr14_12 = 3'd0; Instr30 = 1'b0;

        // Reset state: FETCH, no strobes even with MemReady high
        @(posedge CLK); #1;
        chk("rst_state",   int'(State), 0);
        chk("rst_pcwrite", int'(PCWrite), 0);
        chk("rst_irwrite", int'(IRWrite), 0);
        chk("rst_alusrcb", int'(ALUSrcB), 2);
        MemReady = 1'b0;
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;

        // Reset asserted while MEMWRITE is strobing
        Instr6_0 = SW;
        step(P_F, 1'b1, 1'b0);
        step(P_D, 1'b0, 1'b0);
        step(P_MA, 1'b0, 1'b0);
        MemReady = 1'b0;
        #2;
        chk("mw_before_rst", int'(MemWrite), 1);
        RST = 1'b0; MemReady = 1'b1;
        #1;
        chk("mw_in_rst",    int'(MemWrite), 0);
        chk("state_in_rst", int'(State), 0);
        chk("ir_in_rst",    int'(IRWrite), 0);
        MemReady = 1'b0;
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;

        run_instr(LW, 3'd2, 1'b0, 1'b0, 0);         // lw, no stalls
        run_instr(SW, 3'd2, 1'b0, 1'b0, 3);         // sw, MemReady low 3 cycles
        run_instr(RT, 3'd0, 1'b1, 1'b0, 0);         // sub
        run_instr(IT, 3'd0, 1'b1, 1'b0, 0);         // addi, funct7[5] set
        run_instr(RT, 3'd6, 1'b0, 1'b0, 0);         // or
        run_instr(RT, 3'd7, 1'b0, 1'b0, 0);         // and
        run_instr(IT, 3'd2, 1'b0, 1'b0, 0);         // slti
        run_instr(BQ, 3'd0, 1'b0, 1'b1, 0);         // beq taken
        run_instr(BQ, 3'd0, 1'b0, 1'b0, 0);         // beq not taken
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0); // illegal
        run_instr(JL, 3'd0, 1'b0, 1'b0, 0);         // jal
        run_instr(LW, 3'd2, 1'b0, 1'b0, 2);         // lw with stalls

        for (int i = 0; i < 80; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
